// File: rtl/display_pkg.sv
// Shared display-path definitions: animation mode encodings and default timing.
package display_pkg;

    // Animation playback modes selected by the sprite controller
    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    // 25 MHz pixel clock divided down to 8 animation frames per second
    localparam int CLK_DIV_8FPS = 3125000;

endpackage

// File: rtl/tick_prescaler.sv
// Frame-rate prescaler: counts enabled cycles and flags the cycle on which the
// current animation period has elapsed. The speed select shortens the period
// by powers of two.
module tick_prescaler
    import display_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_8FPS,
    parameter int CNT_W   = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;

    // Terminal count for the selected speed; a >= compare lets a speed-up take
    // effect immediately instead of waiting for the counter to wrap
    always_comb begin
        limit = CNT_W'(CLK_DIV >> speed) - CNT_W'(1);
        tick  = run && (cnt >= limit);
    end

    // Cycle counter: cleared by reset or restart, frozen whenever not running
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/anim_frame_sequencer.sv
// Sprite animation frame sequencer: turns prescaler ticks into a frame index for
// the sprite ROM, supporting loop, ping-pong, one-shot and hold playback.
module anim_frame_sequencer
    import display_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_8FPS,
    parameter int NUM_FRAMES = 16,
    parameter int FRAME_W    = 4,
    parameter int CNT_W      = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  mode_t              mode,
    input  logic [1:0]         speed,
    input  logic               restart,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               dir,
    output logic               done
);

    localparam logic [FRAME_W-1:0] LAST_F   = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] PENULT_F = FRAME_W'((NUM_FRAMES > 1) ? NUM_FRAMES - 2 : 0);

    logic               run;
    logic               tick;
    mode_t              prev_mode;
    logic               mode_changed;
    logic               done_eff;
    logic               dir_eff;
    logic [FRAME_W-1:0] frame_nxt;
    logic               dir_nxt;
    logic               done_nxt;
    logic               tick_nxt;

    assign run = en && (mode != MODE_HOLD);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .run   (run),
        .speed (speed),
        .tick  (tick)
    );

    // Next-state rules: a mode change clears done (and dir outside ping-pong)
    // first, then any tick steps the frame according to the current mode
    always_comb begin
        mode_changed = (mode != prev_mode);
        done_eff     = mode_changed ? 1'b0 : done;
        dir_eff      = (mode_changed && (mode != MODE_PINGPONG)) ? 1'b0 : dir;
        frame_nxt    = frame;
        dir_nxt      = dir_eff;
        done_nxt     = done_eff;
        tick_nxt     = 1'b0;
        if (tick) begin
            if (frame > LAST_F) begin
                frame_nxt = '0;
                dir_nxt   = 1'b0;
                tick_nxt  = 1'b1;
            end else begin
                case (mode)
                    MODE_LOOP: begin
                        frame_nxt = (frame == LAST_F) ? '0 : frame + FRAME_W'(1);
                        dir_nxt   = 1'b0;
                        tick_nxt  = 1'b1;
                    end
                    MODE_PINGPONG: begin
                        tick_nxt = 1'b1;
                        if (NUM_FRAMES == 1) begin
                            frame_nxt = '0;
                            dir_nxt   = 1'b0;
                        end else if (!dir_eff) begin
                            if (frame == LAST_F) begin
                                dir_nxt   = 1'b1;
                                frame_nxt = PENULT_F;
                            end else begin
                                frame_nxt = frame + FRAME_W'(1);
                            end
                        end else begin
                            if (frame == '0) begin
                                dir_nxt   = 1'b0;
                                frame_nxt = FRAME_W'(1);
                            end else begin
                                frame_nxt = frame - FRAME_W'(1);
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        if (!done_eff) begin
                            if (frame == LAST_F) begin
                                done_nxt = 1'b1;
                            end else begin
                                frame_nxt = frame + FRAME_W'(1);
                                tick_nxt  = 1'b1;
                                if (frame + FRAME_W'(1) == LAST_F) begin
                                    done_nxt = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output registers: reset and restart return to frame 0, pause holds everything
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            frame      <= '0;
            frame_tick <= 1'b0;
            dir        <= 1'b0;
            done       <= 1'b0;
            prev_mode  <= mode;
        end else if (en) begin
            frame      <= frame_nxt;
            frame_tick <= tick_nxt;
            dir        <= dir_nxt;
            done       <= done_nxt;
            prev_mode  <= mode;
        end else begin
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Testbench for anim_frame_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural playback model.
module tb_anim_frame_sequencer;
    import display_pkg::*;

    localparam int CLK_DIV    = 8;
    localparam int NUM_FRAMES = 5;
    localparam int FRAME_W    = 3;
    localparam int CNT_W      = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    mode_t              mode;
    logic [1:0]         speed;
    logic               restart;
    logic [FRAME_W-1:0] frame;
    logic               frame_tick;
    logic               dir;
    logic               done;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int    m_cnt;
    int    m_frame;
    logic  m_tick;
    logic  m_dir;
    logic  m_done;
    mode_t m_prev;

    typedef struct {
        string              name;
        logic               rst;
        logic               restart;
        logic               en;
        mode_t              mode;
        logic [1:0]         speed;
        int                 cycles;
        logic [FRAME_W-1:0] exp_frame;
        logic               exp_tick;
        logic               exp_dir;
        logic               exp_done;
    } vec_t;

    vec_t vecs[$];

    logic       rand_rst;
    logic       rand_restart;
    logic       rand_en;
    mode_t      rand_mode;
    logic [1:0] rand_speed;

    anim_frame_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_W    (FRAME_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .speed      (speed),
        .restart    (restart),
        .frame      (frame),
        .frame_tick (frame_tick),
        .dir        (dir),
        .done       (done)
    );

    // 10 ns pixel clock
    always #5 clk = ~clk;

    // Playback model: one call per clock edge, written from the animation rules
    task automatic modelStep(input logic r, input logic rs, input logic e,
                             input mode_t m, input logic [1:0] s);
        int period;
        int step;
        bit advanced;
        if (r || rs) begin
            m_cnt = 0; m_frame = 0; m_tick = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_prev = m;
            return;
        end
        m_tick = 1'b0;
        if (!e) return;
        if (m != m_prev) begin
            m_done = 1'b0;
            if (m != MODE_PINGPONG) m_dir = 1'b0;
        end
        m_prev = m;
        if (m == MODE_HOLD) return;
        period = CLK_DIV >> s;
        advanced = (m_cnt >= period - 1);
        m_cnt = advanced ? 0 : m_cnt + 1;
        if (!advanced) return;
        if (m_frame >= NUM_FRAMES) begin
            m_frame = 0; m_dir = 1'b0; m_tick = 1'b1;
            return;
        end
        case (m)
            MODE_LOOP: begin
                m_frame = (m_frame + 1) % NUM_FRAMES;
                m_dir = 1'b0;
                m_tick = 1'b1;
            end
            MODE_PINGPONG: begin
                m_tick = 1'b1;
                if (NUM_FRAMES > 1) begin
                    step = m_dir ? -1 : 1;
                    if (m_frame + step < 0 || m_frame + step > NUM_FRAMES - 1) begin
                        m_dir = ~m_dir;
                        step = -step;
                    end
                    m_frame = m_frame + step;
                end
            end
            MODE_ONESHOT: begin
                if (!m_done) begin
                    if (m_frame < NUM_FRAMES - 1) begin
                        m_frame = m_frame + 1;
                        m_tick = 1'b1;
                    end
                    if (m_frame == NUM_FRAMES - 1) m_done = 1'b1;
                end
            end
            default: begin
            end
        endcase
    endtask

    task automatic applyStimulus(input logic r, input logic rs, input logic e,
                                 input mode_t m, input logic [1:0] s, input int n);
        rst = r; restart = rs; en = e; mode = m; speed = s;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            modelStep(r, rs, e, m, s);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [FRAME_W-1:0] ef,
                               input logic et, input logic ed, input logic edn);
        checks++;
        if (frame !== ef || frame_tick !== et || dir !== ed || done !== edn) begin
            failures++;
            $display("[TB] FAIL %s: got frame=%0d tick=%0d dir=%0d done=%0d, want frame=%0d tick=%0d dir=%0d done=%0d",
                     name, frame, frame_tick, dir, done, ef, et, ed, edn);
        end
    endtask

    function automatic void addVec(input string n, input logic r, input logic rs, input logic e,
                                   input mode_t m, input logic [1:0] s, input int c,
                                   input logic [FRAME_W-1:0] f, input logic t,
                                   input logic d, input logic dn);
        vec_t v;
        v.name = n; v.rst = r; v.restart = rs; v.en = e; v.mode = m; v.speed = s;
        v.cycles = c; v.exp_frame = f; v.exp_tick = t; v.exp_dir = d; v.exp_done = dn;
        vecs.push_back(v);
    endfunction

    // Main test flow
    initial begin
        rst = 1'b1; restart = 1'b0; en = 1'b0; mode = MODE_LOOP; speed = 2'd0;
        m_cnt = 0; m_frame = 0; m_tick = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_prev = MODE_LOOP;

        addVec("reset",          1, 0, 1, MODE_LOOP,     2'd0,  2, 3'd0, 0, 0, 0);
        addVec("loop_pre_tick",  0, 0, 1, MODE_LOOP,     2'd0,  7, 3'd0, 0, 0, 0);
        addVec("loop_first",     0, 0, 1, MODE_LOOP,     2'd0,  1, 3'd1, 1, 0, 0);
        addVec("loop_tick_low",  0, 0, 1, MODE_LOOP,     2'd0,  1, 3'd1, 0, 0, 0);
        addVec("loop_f2",        0, 0, 1, MODE_LOOP,     2'd0,  7, 3'd2, 1, 0, 0);
        addVec("loop_f4",        0, 0, 1, MODE_LOOP,     2'd0, 16, 3'd4, 1, 0, 0);
        addVec("loop_wrap",      0, 0, 1, MODE_LOOP,     2'd0,  8, 3'd0, 1, 0, 0);
        addVec("pp_restart",     0, 1, 1, MODE_PINGPONG, 2'd1,  1, 3'd0, 0, 0, 0);
        addVec("pp_f1",          0, 0, 1, MODE_PINGPONG, 2'd1,  4, 3'd1, 1, 0, 0);
        addVec("pp_f4",          0, 0, 1, MODE_PINGPONG, 2'd1, 12, 3'd4, 1, 0, 0);
        addVec("pp_turn_down",   0, 0, 1, MODE_PINGPONG, 2'd1,  4, 3'd3, 1, 1, 0);
        addVec("pp_f0",          0, 0, 1, MODE_PINGPONG, 2'd1, 12, 3'd0, 1, 1, 0);
        addVec("pp_turn_up",     0, 0, 1, MODE_PINGPONG, 2'd1,  4, 3'd1, 1, 0, 0);
        addVec("os_restart",     0, 1, 1, MODE_ONESHOT,  2'd2,  1, 3'd0, 0, 0, 0);
        addVec("os_f1",          0, 0, 1, MODE_ONESHOT,  2'd2,  2, 3'd1, 1, 0, 0);
        addVec("os_done",        0, 0, 1, MODE_ONESHOT,  2'd2,  6, 3'd4, 1, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].restart, vecs[i].en, vecs[i].mode,
                          vecs[i].speed, vecs[i].cycles);
            checkOutput(vecs[i].name, vecs[i].exp_frame, vecs[i].exp_tick,
                        vecs[i].exp_dir, vecs[i].exp_done);
        end

        // One-shot stays parked on the last frame until restarted
        for (int c = 0; c < 20; c++) begin
            applyStimulus(0, 0, 1, MODE_ONESHOT, 2'd2, 1);
            checkOutput("os_parked", 3'd4, 0, 0, 1);
        end
        applyStimulus(0, 1, 1, MODE_ONESHOT, 2'd2, 1);
        checkOutput("os_restart2", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_ONESHOT, 2'd2, 1);
        checkOutput("os_wait", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_ONESHOT, 2'd2, 1);
        checkOutput("os_next", 3'd1, 1, 0, 0);

        // Mode change out of a finished one-shot, then hold and resume
        applyStimulus(0, 0, 1, MODE_ONESHOT, 2'd2, 6);
        checkOutput("os_done2", 3'd4, 1, 0, 1);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd2, 1);
        checkOutput("mc_done_clr", 3'd4, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd2, 1);
        checkOutput("mc_wrap", 3'd0, 1, 0, 0);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(0, 0, 1, MODE_HOLD, 2'd2, 1);
            checkOutput("hold", 3'd0, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd2, 1);
        checkOutput("hold_resume", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd2, 1);
        checkOutput("hold_resume_tick", 3'd1, 1, 0, 0);

        // Pause at cnt=5, then resume at the same speed and at a faster one
        applyStimulus(0, 1, 1, MODE_LOOP, 2'd0, 1);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 5);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 0, MODE_LOOP, 2'd0, 1);
            checkOutput("pause", 3'd0, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 2);
        checkOutput("pause_cnt_kept", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 1);
        checkOutput("pause_resume_tick", 3'd1, 1, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 5);
        applyStimulus(0, 0, 0, MODE_LOOP, 2'd0, 3);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd3, 1);
        checkOutput("speedup_tick", 3'd2, 1, 0, 0);

        // Reset in mid-period, then restart on the same edge as a tick
        applyStimulus(0, 1, 1, MODE_LOOP, 2'd0, 1);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 30);
        checkOutput("mid_f3", 3'd3, 0, 0, 0);
        applyStimulus(1, 0, 1, MODE_LOOP, 2'd0, 1);
        checkOutput("mid_reset", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 15);
        checkOutput("pre_restart", 3'd1, 0, 0, 0);
        applyStimulus(0, 1, 1, MODE_LOOP, 2'd0, 1);
        checkOutput("restart_on_tick", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 7);
        checkOutput("restart_wait", 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 1, MODE_LOOP, 2'd0, 1);
        checkOutput("restart_first", 3'd1, 1, 0, 0);

        // Randomized run against the playback model
        rand_mode = MODE_LOOP;
        rand_speed = 2'd0;
        applyStimulus(1, 0, 1, rand_mode, rand_speed, 1);
        for (int i = 0; i < 800; i++) begin
            rand_rst = ($urandom_range(0, 199) == 0);
            rand_restart = ($urandom_range(0, 59) == 0);
            rand_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) rand_mode = mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) rand_speed = 2'($urandom_range(0, 3));
            applyStimulus(rand_rst, rand_restart, rand_en, rand_mode, rand_speed, 1);
            checkOutput("random", FRAME_W'(m_frame), m_tick, m_dir, m_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
